// File: rtl/mem_data_ram_ctrl.sv
// MEM-stage data RAM: byte-enabled XLEN-wide storage with sized, sign/zero-extending loads,
// misalignment/range fault flags and a post-reset zeroing sweep of the whole array.
`ifndef XLEN_64b
  `define XLEN_64b 2'd2
`endif
`ifndef GLOBAL_LO
  `define GLOBAL_LO 'h1000
`endif
`ifndef M_STACK_HI
  `define M_STACK_HI 'h1FFF
`endif

module mem_data_ram_ctrl #(
  parameter logic [1:0]  XLEN      = `XLEN_64b,
  parameter logic [63:0] BASE_ADDR = `GLOBAL_LO,
  parameter int unsigned DEPTH     = `M_STACK_HI - `GLOBAL_LO + 1,
  parameter              INIT_FILE = "./Mem_Files/ram_data.mem",
  localparam int unsigned XW       = 1 << (32'(XLEN) + 4)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_write,
  input  logic [XW-1:0] i_req_addr,
  input  logic [XW-1:0] i_req_wdata,
  input  logic [1:0]    i_req_size,
  input  logic          i_req_unsigned,
  output logic          o_rsp_valid,
  output logic [XW-1:0] o_rsp_rdata,
  output logic          o_rsp_misaligned,
  output logic          o_rsp_oob,
  output logic          o_clear_busy
);

  localparam int unsigned NB     = XW / 8;
  localparam int unsigned LNB    = $clog2(NB);
  localparam int unsigned NWORDS = DEPTH / NB;
  localparam int unsigned WIW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIW-1:0] LAST_IDX = WIW'(NWORDS - 1);
  localparam logic [XW:0]    DEPTH_W  = (XW + 1)'(DEPTH);

  // The reset sweep zeroes every word before the first access, so any preloaded
  // image only matters to flows that bypass reset.
  if (INIT_FILE == "") begin : g_no_init_image
  end

  typedef enum logic {CLEAR, READY} state_e;

  state_e          state_q;
  logic [WIW-1:0]  cnt_q;
  logic            ready_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic [XW-1:0]   rdata_q;
  logic            mis_q;
  logic            oob_q;

  logic [XW-1:0]   mem [NWORDS];

  logic [XW-1:0]   off;
  logic [LNB-1:0]  lane;
  logic [WIW-1:0]  widx;
  logic [3:0]      nbytes;
  logic [XW:0]     off_end;
  logic [2:0]      amask;
  logic [7:0]      be8;
  logic [NB-1:0]   be;
  logic            mis;
  logic            oob;
  logic            fault;
  logic            accept;
  logic [XW-1:0]   rword;
  logic [XW-1:0]   sh;
  logic [XW-1:0]   keep;
  logic            sbit;
  logic [XW-1:0]   ext;

  logic [NB-1:0]   mem_be;
  logic [WIW-1:0]  mem_idx;
  logic [XW-1:0]   mem_wd;

  assign off     = i_req_addr - BASE_ADDR[XW-1:0];
  assign lane    = off[LNB-1:0];
  assign widx    = off[LNB +: WIW];
  assign nbytes  = 4'd1 << i_req_size;
  assign off_end = {1'b0, off} + (XW + 1)'(nbytes);
  assign accept  = i_req_valid & ready_q & i_clk_en & ~i_rst;

  always_comb begin
    amask = 3'b000;
    be8   = 8'h01;
    keep  = '1;
    sbit  = 1'b0;
    rword = mem[widx];
    sh    = rword >> {lane, 3'b000};
    unique case (i_req_size)
      2'd0: begin amask = 3'b000; be8 = 8'h01; keep = XW'(8'hFF);         sbit = sh[7];    end
      2'd1: begin amask = 3'b001; be8 = 8'h03; keep = XW'(16'hFFFF);      sbit = sh[15];   end
      2'd2: begin amask = 3'b011; be8 = 8'h0F; keep = XW'(32'hFFFF_FFFF); sbit = sh[31];   end
      default: begin amask = 3'b111; be8 = 8'hFF; keep = '1;              sbit = sh[XW-1]; end
    endcase
    be    = NB'(be8) << lane;
    mis   = (|(i_req_addr[2:0] & amask)) | ((i_req_size == 2'd3) && (XW == 32));
    oob   = ({1'b0, off} >= DEPTH_W) | (off_end > DEPTH_W);
    fault = mis | oob;
    ext   = (i_req_unsigned || !sbit) ? (sh & keep) : (sh | ~keep);
  end

  // The sweep and store traffic share one byte-enabled write port.
  always_comb begin
    mem_be  = '0;
    mem_idx = widx;
    mem_wd  = i_req_wdata << {lane, 3'b000};
    if (i_clk_en && !i_rst) begin
      if (state_q == CLEAR) begin
        mem_be  = '1;
        mem_idx = cnt_q;
        mem_wd  = '0;
      end else if (accept && i_req_write && !fault) begin
        mem_be  = be;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wd[b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
      oob_q       <= 1'b0;
    end else if (i_clk_en) begin
      unique case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= READY;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
      rsp_valid_q <= accept;
      if (accept) begin
        rdata_q <= (i_req_write || fault) ? '0 : ext;
        mis_q   <= mis;
        oob_q   <= oob;
      end
    end
  end

  assign o_req_ready      = ready_q;
  assign o_clear_busy     = busy_q;
  assign o_rsp_valid      = rsp_valid_q;
  assign o_rsp_rdata      = rdata_q;
  assign o_rsp_misaligned = mis_q;
  assign o_rsp_oob        = oob_q;

endmodule

// File: tb/tb_mem_data_ram_ctrl.sv
// Scoreboard bench for mem_data_ram_ctrl: directed requests push expected responses,
// an independent monitor pops and compares on every enabled response strobe.
module tb_mem_data_ram_ctrl;

  localparam logic [63:0] BASE  = 64'h1000;
  localparam int          DEPTH = 64;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_clk_en;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic        o_rsp_valid;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_misaligned;
  logic        o_rsp_oob;
  logic        o_clear_busy;

  always #5 i_clk = ~i_clk;

  mem_data_ram_ctrl #(
    .XLEN      (2'd2),
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_clk_en         (i_clk_en),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_write      (i_req_write),
    .i_req_addr       (i_req_addr),
    .i_req_wdata      (i_req_wdata),
    .i_req_size       (i_req_size),
    .i_req_unsigned   (i_req_unsigned),
    .o_rsp_valid      (o_rsp_valid),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_rsp_misaligned (o_rsp_misaligned),
    .o_rsp_oob        (o_rsp_oob),
    .o_clear_busy     (o_clear_busy)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    logic        oob;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic en_e  = 1'b0;
  logic rst_e = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  always @(posedge i_clk) begin
    en_e  = i_clk_en;
    rst_e = i_rst;
  end

  always @(negedge i_clk) begin
    if (en_e && !rst_e && o_rsp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata %h, required no response", o_rsp_rdata);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", o_rsp_rdata, e.rdata);
        chk("rsp_misaligned", 64'(o_rsp_misaligned), 64'(e.mis));
        chk("rsp_oob", 64'(o_rsp_oob), 64'(e.oob));
      end
    end
  end

  task automatic req(input logic w, input logic [63:0] a, input logic [63:0] d,
                     input logic [1:0] sz, input logic u,
                     input logic [63:0] er, input logic em, input logic eo);
    i_req_valid    = 1'b1;
    i_req_write    = w;
    i_req_addr     = a;
    i_req_wdata    = d;
    i_req_size     = sz;
    i_req_unsigned = u;
    sb.push_back('{er, em, eo});
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic sweep_len(input string nm);
    int n = 0;
    while (!o_req_ready && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    i_req_valid = 1'b0;
    chk(nm, 64'(n), 64'd8);
    chk("busy_after_sweep", 64'(o_clear_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_clk_en = 1'b1; i_req_valid = 1'b0; i_req_write = 1'b0;
    i_req_addr = '0; i_req_wdata = '0; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    @(negedge i_clk);
    chk("reset_ready", 64'(o_req_ready), 64'd0);
    chk("reset_valid", 64'(o_rsp_valid), 64'd0);
    chk("reset_rdata", o_rsp_rdata, 64'd0);
    chk("reset_mis", 64'(o_rsp_misaligned), 64'd0);
    chk("reset_oob", 64'(o_rsp_oob), 64'd0);
    chk("reset_busy", 64'(o_clear_busy), 64'd1);
    i_rst = 1'b0;
    // A store offered during the sweep must be ignored.
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = BASE; i_req_wdata = 64'hFFFF; i_req_size = 2'd3;
    sweep_len("sweep_len");

    req(0, BASE,          0,                     2'd3, 0, 64'h0,                 0, 0);
    req(1, BASE,          64'h8877665544332211,  2'd3, 0, 64'h0,                 0, 0);
    req(0, BASE + 7,      0,                     2'd0, 0, 64'hFFFFFFFFFFFFFF88,  0, 0);
    req(0, BASE + 7,      0,                     2'd0, 1, 64'h88,                0, 0);
    req(0, BASE + 2,      0,                     2'd1, 0, 64'h4433,              0, 0);
    req(1, BASE + 3,      64'h12345678_9ABCDEAA, 2'd0, 0, 64'h0,                 0, 0);
    req(0, BASE,          0,                     2'd3, 0, 64'h88776655AA332211,  0, 0);
    req(0, BASE + 4,      0,                     2'd2, 0, 64'hFFFFFFFF88776655,  0, 0);
    req(0, BASE + 4,      0,                     2'd2, 1, 64'h0000000088776655,  0, 0);
    req(1, BASE + 2,      64'h00000000CAFEF00D,  2'd2, 0, 64'h0,                 1, 0);
    req(0, BASE,          0,                     2'd3, 0, 64'h88776655AA332211,  0, 0);
    req(0, BASE + DEPTH,  0,                     2'd3, 0, 64'h0,                 0, 1);
    req(1, BASE + 56,     64'h11111111DEADBEEF,  2'd2, 0, 64'h0,                 0, 0);
    req(1, BASE + DEPTH - 1, 64'hBEEF,           2'd1, 0, 64'h0,                 1, 1);
    req(0, BASE + 56,     0,                     2'd3, 0, 64'h00000000DEADBEEF,  0, 0);
    req(0, BASE + 58,     0,                     2'd1, 1, 64'hDEAD,              0, 0);
    req(0, BASE + 58,     0,                     2'd1, 0, 64'hFFFFFFFFFFFFDEAD,  0, 0);
    req(0, BASE - 8,      0,                     2'd3, 0, 64'h0,                 0, 1);
    req(0, BASE,          0,                     2'd0, 0, 64'h11,                0, 0);
    idle();

    // Stall: response must hold while the clock enable is low.
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = BASE; i_req_size = 2'd3; i_req_unsigned = 1'b0;
    sb.push_back('{64'h88776655AA332211, 1'b0, 1'b0});
    @(negedge i_clk);
    i_clk_en = 1'b0;
    i_req_addr = BASE + 56;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("stall_valid", 64'(o_rsp_valid), 64'd1);
      chk("stall_rdata", o_rsp_rdata, 64'h88776655AA332211);
    end
    i_req_valid = 1'b0;
    i_clk_en = 1'b1;
    @(negedge i_clk);
    chk("post_stall_valid", 64'(o_rsp_valid), 64'd0);

    // Reset while a response is in flight, with a request held during reset.
    req(0, BASE + 56, 0, 2'd3, 0, 64'h00000000DEADBEEF, 0, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst_valid", 64'(o_rsp_valid), 64'd0);
    chk("midrst_ready", 64'(o_req_ready), 64'd0);
    chk("midrst_busy", 64'(o_clear_busy), 64'd1);
    i_rst = 1'b0;
    i_req_write = 1'b1; i_req_addr = BASE; i_req_wdata = 64'h55;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    sweep_len("sweep_restart_len");

    req(0, BASE,      0, 2'd3, 0, 64'h0, 0, 0);
    req(0, BASE + 56, 0, 2'd3, 0, 64'h0, 0, 0);
    idle();
    idle();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
